// File: rtl/weight_wr_pkg.sv
// weight_wr_pkg: FSM encoding and write-gap limits shared by the weight write master.
package weight_wr_pkg;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam int WR_GAP_MAX = 15;
    localparam int GAP_W = 4;
endpackage

// File: rtl/weight_wr_if.sv
// weight_wr_if: control, stream-in and PE weight-bus signals of the weight write master.
interface weight_wr_if #(parameter int DATA_WIDTH = 16, parameter int ADDR_WIDTH = 32);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH-1:0] num_words;
    logic                  abort;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] weight_wr_data;
    logic [ADDR_WIDTH-1:0] weight_wr_addr;
    logic                  weight_wr_en;
    logic                  busy;
    logic                  done;
    modport master (
        input  start, base_addr, num_words, abort, s_data, s_valid,
        output s_ready, weight_wr_data, weight_wr_addr, weight_wr_en, busy, done
    );
    modport slave (
        output start, base_addr, num_words, abort, s_data, s_valid,
        input  s_ready, weight_wr_data, weight_wr_addr, weight_wr_en, busy, done
    );
endinterface

// File: rtl/weight_wr_gap_cnt.sv
// weight_wr_gap_cnt: loadable down-counter timing the idle gap between weight writes.
module weight_wr_gap_cnt #(parameter int W = 4) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    input  logic         dec_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q;
    assign zero_o = cnt_q == '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else if (load_i) cnt_q <= val_i;
        else if (dec_i && !zero_o) cnt_q <= cnt_q - 1'b1;
    end
endmodule

// File: rtl/weight_wr_master.sv
// weight_wr_master: streams num_words weights into consecutive PE weight-bus addresses,
// inserting WR_GAP idle cycles between writes.
module weight_wr_master import weight_wr_pkg::*; #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int WR_GAP     = 1
) (
    input logic         clk,
    input logic         rst,
    weight_wr_if.master bus
);
    localparam logic [ADDR_WIDTH-1:0] ONE = 1;
    localparam int GAP_CLAMP = WR_GAP > WR_GAP_MAX ? WR_GAP_MAX : WR_GAP;
    // Counter is loaded at the handshake, so GAP lasts exactly WR_GAP cycles.
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CLAMP > 0 ? GAP_CLAMP - 1 : 0);
    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, num_q, cnt_q, addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  en_q, done_q, hs, last, gap_zero;
    assign bus.s_ready        = state_q == S_LOAD && !bus.abort;
    assign hs                 = bus.s_valid && bus.s_ready;
    assign last               = cnt_q == num_q - ONE;
    assign bus.busy           = state_q != S_IDLE;
    assign bus.done           = done_q;
    assign bus.weight_wr_en   = en_q;
    assign bus.weight_wr_data = data_q;
    assign bus.weight_wr_addr = addr_q;
    weight_wr_gap_cnt #(.W(GAP_W)) u_gap (
        .clk    (clk),
        .rst    (rst),
        .load_i (hs),
        .val_i  (GAP_LOAD),
        .dec_i  (state_q == S_GAP),
        .zero_o (gap_zero)
    );
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:  state_d = !bus.start ? S_IDLE : (bus.num_words == '0) ? S_DONE : S_LOAD;
            S_LOAD:  state_d = bus.abort ? S_DONE : !hs ? S_LOAD : last ? S_DONE :
                               (GAP_CLAMP == 0) ? S_LOAD : S_GAP;
            S_GAP:   state_d = bus.abort ? S_DONE : gap_zero ? S_LOAD : S_GAP;
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            num_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= hs;
            done_q  <= state_q == S_DONE;
            if (state_q == S_IDLE && bus.start) begin
                base_q <= bus.base_addr;
                num_q  <= bus.num_words;
                cnt_q  <= '0;
            end
            if (hs) begin
                cnt_q  <= cnt_q + ONE;
                data_q <= bus.s_data;
                addr_q <= base_q + cnt_q;
            end
        end
    end
endmodule

// File: tb/tb_weight_wr_master.sv
// tb_weight_wr_master: directed checks of the weight write master with WR_GAP=0 and WR_GAP=2.
module tb_weight_wr_master;
    logic        clk = 1'b0, rst = 1'b1, sel = 1'b0;
    logic        start = 1'b0, abort = 1'b0, s_valid = 1'b0;
    logic [31:0] base_addr = '0, num_words = '0;
    logic [15:0] sdata;
    int          cyc = 0, checks = 0, failures = 0;
    int          done_cnt, done_cyc, busy_cnt, rdy_cnt;
    int          wcyc[$];
    logic [31:0] waddr[$];
    logic [15:0] wdata[$];
    logic        en, busy, done, rdy;
    logic [31:0] addr;
    logic [15:0] data;
    weight_wr_if #(.DATA_WIDTH(16), .ADDR_WIDTH(32)) i0 ();
    weight_wr_if #(.DATA_WIDTH(16), .ADDR_WIDTH(32)) i2 ();
    weight_wr_master #(.DATA_WIDTH(16), .ADDR_WIDTH(32), .WR_GAP(0)) u0 (.clk(clk), .rst(rst), .bus(i0));
    weight_wr_master #(.DATA_WIDTH(16), .ADDR_WIDTH(32), .WR_GAP(2)) u2 (.clk(clk), .rst(rst), .bus(i2));
    assign sdata = 16'hA000 + 16'(cyc);
    assign {i0.start, i0.abort, i0.s_valid, i0.base_addr, i0.num_words, i0.s_data} =
           {start, abort, s_valid, base_addr, num_words, sdata};
    assign {i2.start, i2.abort, i2.s_valid, i2.base_addr, i2.num_words, i2.s_data} =
           {start, abort, s_valid, base_addr, num_words, sdata};
    assign en   = sel ? i2.weight_wr_en   : i0.weight_wr_en;
    assign busy = sel ? i2.busy           : i0.busy;
    assign done = sel ? i2.done           : i0.done;
    assign rdy  = sel ? i2.s_ready        : i0.s_ready;
    assign addr = sel ? i2.weight_wr_addr : i0.weight_wr_addr;
    assign data = sel ? i2.weight_wr_data : i0.weight_wr_data;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (en) begin
            wcyc.push_back(cyc);
            waddr.push_back(addr);
            wdata.push_back(data);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy) busy_cnt++;
        if (rdy) rdy_cnt++;
    end
    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic clear();
        wcyc.delete();
        waddr.delete();
        wdata.delete();
        done_cnt = 0;
        done_cyc = -1;
        busy_cnt = 0;
        rdy_cnt  = 0;
    endtask
    task automatic go(input logic [31:0] b, input logic [31:0] n, output int s);
        clear();
        base_addr = b;
        num_words = n;
        start     = 1'b1;
        s         = cyc;
        tick(1);
        start     = 1'b0;
    endtask
    task automatic check_writes(int s, logic [31:0] b, int n, int step);
        check("nwr", 64'(wcyc.size()), 64'(n));
        for (int i = 0; i < n && i < wcyc.size(); i++) begin
            check("wr_addr", 64'(waddr[i]), 64'(32'(b + 32'(i))));
            check("wr_cyc", 64'(wcyc[i]), 64'(s + 2 + i * step));
            check("wr_data", 64'(wdata[i]), 64'(16'hA000 + 16'(s + 1 + i * step)));
        end
    endtask
    initial begin
        int s;
        clear();
        tick(3);
        check("rst_en", 64'(en), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_rdy", 64'(rdy), 0);
        check("rst_addr", 64'(addr), 0);
        check("rst_data", 64'(data), 0);
        rst = 1'b0;
        s_valid = 1'b1;
        tick(2);
        // back-to-back writes, no gap
        go(32'd23, 32'd4, s);
        tick(20);
        check_writes(s, 32'd23, 4, 1);
        check("b2b_done_cyc", 64'(done_cyc), 64'(s + 6));
        check("b2b_done_cnt", 64'(done_cnt), 1);
        check("b2b_busy", 64'(busy_cnt), 5);
        // two idle cycles between writes
        sel = 1'b1;
        go(32'd100, 32'd3, s);
        tick(20);
        check_writes(s, 32'd100, 3, 3);
        check("gap_rdy", 64'(rdy_cnt), 3);
        check("gap_done_cyc", 64'(done_cyc), 64'(s + 9));
        check("gap_busy", 64'(busy_cnt), 8);
        sel = 1'b0;
        // abort in idle must be harmless, then an empty load
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("idle_abort_busy", 64'(busy), 0);
        go(32'd7, 32'd0, s);
        tick(20);
        check("zero_nwr", 64'(wcyc.size()), 0);
        check("zero_done_cyc", 64'(done_cyc), 64'(s + 2));
        check("zero_busy", 64'(busy_cnt), 1);
        check("zero_done_cnt", 64'(done_cnt), 1);
        // abort after two of eight words
        go(32'd300, 32'd8, s);
        tick(2);
        abort = 1'b1;
        #1;
        check("abort_rdy", 64'(rdy), 0);
        tick(1);
        abort = 1'b0;
        tick(20);
        check_writes(s, 32'd300, 2, 1);
        check("abort_done_cyc", 64'(done_cyc), 64'(s + 5));
        check("abort_done_cnt", 64'(done_cnt), 1);
        // reset mid-load, then a fresh load
        go(32'd200, 32'd8, s);
        tick(2);
        check("pre_rst_en", 64'(en), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_en", 64'(en), 0);
        check("mid_rst_busy", 64'(busy), 0);
        check("mid_rst_rdy", 64'(rdy), 0);
        check("mid_rst_addr", 64'(addr), 0);
        check("mid_rst_data", 64'(data), 0);
        check("mid_rst_done", 64'(done), 0);
        tick(1);
        rst = 1'b0;
        clear();
        tick(4);
        check("rst_exit_done", 64'(done_cnt), 0);
        check("rst_exit_nwr", 64'(wcyc.size()), 0);
        go(32'd50, 32'd2, s);
        tick(20);
        check_writes(s, 32'd50, 2, 1);
        check("post_rst_done_cyc", 64'(done_cyc), 64'(s + 4));
        // address wrap, with a start while busy that must be ignored
        go(32'hFFFF_FFFE, 32'd3, s);
        base_addr = 32'h1234;
        num_words = 32'd1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(20);
        check_writes(s, 32'hFFFF_FFFE, 3, 1);
        check("wrap_done_cnt", 64'(done_cnt), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
